spi_adc_rx: RTL and testbench

Serial-ADC read controller for the spiadc datapath. Consumes the half-period enable `tick` produced by the free-running mod-M tick counter and generates `cs_n`/`sclk` for a 16-clock serial ADC frame (leading zeros + DW data bits, MSB first). It shifts in `miso` and presents each parallel sample with a one-cycle `done_tick` to the downstream consumer. SPI mode CPOL=1: ADC updates on falling `sclk`, block samples on rising `sclk`.

---
 rtl/spi_adc_rx_pkg.sv | 18 +
 rtl/spi_adc_rx.sv | 129 ++++++++++++
 tb/tb_spi_adc_rx.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_adc_rx_pkg.sv
// spi_adc_rx_pkg: shared types and defaults for the spiadc serial-ADC reader.
// Holds the controller state encoding and the default frame geometry of the target ADC.
package spi_adc_rx_pkg;

   // Controller states; the encoding is shared with the rest of the spiadc datapath.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   // Default geometry of the target ADC: 16-clock frame, 12 data bits at the end.
   localparam int DEF_DW    = 12;
   localparam int DEF_FRAME = 16;
   localparam int DEF_QUIET = 2;

endpackage

// File: rtl/spi_adc_rx.sv
// spi_adc_rx: CPOL=1 serial-ADC read controller driven by a half-period tick enable.
// Ports: clk, reset (async active-low), tick, start, miso -> cs_n, sclk, data[DW], done_tick, busy.
module spi_adc_rx
   import spi_adc_rx_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int FRAME = DEF_FRAME,
   parameter int QUIET = DEF_QUIET
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick,
   input  logic          start,
   input  logic          miso,
   output logic          cs_n,
   output logic          sclk,
   output logic [DW-1:0] data,
   output logic          done_tick,
   output logic          busy
);

   localparam int BW = $clog2(FRAME + 1);
   localparam int QW = $clog2(QUIET + 1);

   localparam logic [BW-1:0] LAST_BIT = BW'(FRAME - 1);
   localparam logic [QW-1:0] LAST_Q   = QW'(QUIET - 1);

   state_e        state_q, state_d;
   logic          cs_n_q, cs_n_d;
   logic          sclk_q, sclk_d;
   logic          done_q, done_d;
   logic [DW-1:0] sr_q, sr_d;
   logic [DW-1:0] data_q, data_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [QW-1:0] qcnt_q, qcnt_d;

   // Shift register with the current miso bit appended; the oldest bit
   // falls off the top, so leading frame bits beyond DW are discarded.
   logic [DW-1:0] sr_next;
   assign sr_next = DW'({sr_q, miso});

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b1;
         done_q  <= 1'b0;
         sr_q    <= '0;
         data_q  <= '0;
         bcnt_q  <= '0;
         qcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cs_n_q  <= cs_n_d;
         sclk_q  <= sclk_d;
         done_q  <= done_d;
         sr_q    <= sr_d;
         data_q  <= data_d;
         bcnt_q  <= bcnt_d;
         qcnt_q  <= qcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cs_n_d  = cs_n_q;
      sclk_d  = sclk_q;
      done_d  = 1'b0;
      sr_d    = sr_q;
      data_d  = data_q;
      bcnt_d  = bcnt_q;
      qcnt_d  = qcnt_q;

      unique case (state_q)
         // tick is deliberately ignored here so the first sclk fall
         // always lands on a tick strictly after cs_n has dropped.
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SETUP;
               cs_n_d  = 1'b0;
               bcnt_d  = '0;
               sr_d    = '0;
            end
         end
         ST_SETUP: begin
            if (tick) begin
               sclk_d  = 1'b0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (tick) begin
               sclk_d = ~sclk_q;
               // sclk low now means this tick is a rising edge: sample miso.
               if (!sclk_q) begin
                  sr_d   = sr_next;
                  bcnt_d = bcnt_q + BW'(1);
                  if (bcnt_q == LAST_BIT) begin
                     cs_n_d  = 1'b1;
                     data_d  = sr_next;
                     done_d  = 1'b1;
                     qcnt_d  = '0;
                     state_d = ST_HOLD;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (tick) begin
               if (qcnt_q == LAST_Q) begin
                  state_d = ST_IDLE;
               end else begin
                  qcnt_d = qcnt_q + QW'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign cs_n      = cs_n_q;
   assign sclk      = sclk_q;
   assign data      = data_q;
   assign done_tick = done_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_adc_rx.sv
// tb_spi_adc_rx: directed + randomized bench for spi_adc_rx with an ADC frame model.
// Runs a DW=12 and a DW=10 instance side by side on the same serial stream.
module tb_spi_adc_rx;

   localparam int FRAME = 16;
   localparam int QUIET = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        tick = 1'b0;
   logic        start = 1'b0;
   logic        miso = 1'b0;
   logic        cs_n, sclk, done_tick, busy;
   logic [11:0] data;
   logic        cs_n10, sclk10, done10, busy10;
   logic [9:0]  data10;

   int checks = 0;
   int failures = 0;

   int m = 4;
   int tcnt = 0;
   bit tick_en = 1'b1;

   logic [15:0] words_q[$];
   logic [15:0] exp_q[$];
   logic [15:0] cur = '0;
   int bit_idx = 0;
   int rises = 0;
   int dones = 0;
   int dones10 = 0;
   int starts = 0;
   logic cs_prev = 1'b1;
   logic sclk_prev = 1'b1;

   always #5 clk = ~clk;

   spi_adc_rx #(.DW(12), .FRAME(FRAME), .QUIET(QUIET)) dut (
      .clk(clk), .reset(reset), .tick(tick), .start(start), .miso(miso),
      .cs_n(cs_n), .sclk(sclk), .data(data), .done_tick(done_tick), .busy(busy)
   );

   spi_adc_rx #(.DW(10), .FRAME(FRAME), .QUIET(QUIET)) dut10 (
      .clk(clk), .reset(reset), .tick(tick), .start(start), .miso(miso),
      .cs_n(cs_n10), .sclk(sclk10), .data(data10), .done_tick(done10), .busy(busy10)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: runs at the falling edge, models the ADC, counts edges,
   // then drives the mod-m tick for the next rising edge.
   task automatic cyc();
      @(negedge clk);
      if (cs_prev && !cs_n) begin
         bit_idx = 0;
         rises = 0;
         starts++;
         cur = (words_q.size() != 0) ? words_q.pop_front() : 16'($urandom);
         exp_q.push_back(cur);
      end
      if (sclk_prev && !sclk && !cs_n && bit_idx < FRAME) begin
         miso = cur[FRAME-1-bit_idx];
         bit_idx++;
      end
      if (!sclk_prev && sclk && !cs_prev) rises++;
      if (done_tick) dones++;
      if (done10) dones10++;
      sclk_prev = sclk;
      cs_prev = cs_n;
      tcnt = (tcnt >= m - 1) ? 0 : tcnt + 1;
      tick = tick_en && (tcnt == m - 1);
   endtask

   task automatic wait_done(input string tag, input bit poke_hold);
      int n;
      int nt;
      logic [15:0] w;
      n = 0;
      while (!done_tick && n < 5000) begin
         cyc();
         n++;
      end
      check({tag, " done_seen"}, 32'(n < 5000), 1);
      if (n >= 5000) return;
      w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      check({tag, " data12"}, data, w[11:0]);
      check({tag, " data10"}, data10, w[9:0]);
      check({tag, " done10"}, done10, 1);
      check({tag, " rises"}, rises, FRAME);
      check({tag, " cs_n_hi"}, cs_n, 1);
      check({tag, " sclk_hi"}, sclk, 1);
      nt = tick ? 1 : 0;
      if (poke_hold) start = 1'b1;
      n = 0;
      do begin
         cyc();
         if (poke_hold) start = 1'b0;
         if (!busy) break;
         if (tick) nt++;
         n++;
      end while (n < 5000);
      check({tag, " quiet_ticks"}, nt, QUIET);
   endtask

   task automatic run_until_rises(input int r);
      int n;
      n = 0;
      while (rises < r && n < 5000) begin
         cyc();
         n++;
      end
      check("rises_reached", 32'(n < 5000), 1);
   endtask

   initial begin
      int s0, d0, k, n;
      logic [15:0] w;

      // Reset state
      repeat (3) cyc();
      check("rst cs_n", cs_n, 1);
      check("rst sclk", sclk, 1);
      check("rst data", data, 0);
      check("rst done", done_tick, 0);
      check("rst busy", busy, 0);
      reset = 1'b1;
      repeat (3) cyc();

      // Basic frame, M=4
      m = 4;
      words_q.push_back(16'h0AC3);
      start = 1'b1;
      cyc();
      start = 1'b0;
      wait_done("basic", 1'b0);

      // DW=10 pattern
      words_q.push_back(16'b0000_1111_0000_1101);
      start = 1'b1;
      cyc();
      start = 1'b0;
      wait_done("dw10", 1'b0);

      // start pulses in SHIFT and HOLD are ignored
      s0 = starts;
      d0 = dones;
      words_q.push_back(16'h0123);
      start = 1'b1;
      cyc();
      start = 1'b0;
      run_until_rises(5);
      start = 1'b1;
      cyc();
      start = 1'b0;
      wait_done("ignore", 1'b1);
      repeat (60) cyc();
      check("ignore busy", busy, 0);
      check("ignore starts", starts - s0, 1);
      check("ignore dones", dones - d0, 1);

      // start held for three frames
      s0 = starts;
      d0 = dones;
      words_q.push_back(16'h0FFF);
      words_q.push_back(16'h0000);
      words_q.push_back(16'h0555);
      start = 1'b1;
      wait_done("b2b0", 1'b0);
      wait_done("b2b1", 1'b0);
      n = 0;
      while (starts < s0 + 3 && n < 5000) begin
         cyc();
         n++;
      end
      start = 1'b0;
      wait_done("b2b2", 1'b0);
      repeat (40) cyc();
      check("b2b dones", dones - d0, 3);
      check("b2b starts", starts - s0, 3);

      // start coincident with tick while idle
      n = 0;
      do begin
         cyc();
         n++;
      end while (!tick && n < 100);
      check("coin busy0", busy, 0);
      words_q.push_back(16'h0F0F);
      start = 1'b1;
      cyc();
      start = 1'b0;
      check("coin cs_n", cs_n, 0);
      check("coin sclk", sclk, 1);
      k = 1;
      while (sclk && k < 100) begin
         cyc();
         k++;
      end
      check("coin first_fall", k, m + 1);
      wait_done("coin", 1'b0);

      // Reset after the 7th rising edge
      d0 = dones;
      words_q.push_back(16'h0ABC);
      start = 1'b1;
      cyc();
      start = 1'b0;
      run_until_rises(7);
      #1;
      reset = 1'b0;
      #1;
      check("arst cs_n", cs_n, 1);
      check("arst sclk", sclk, 1);
      check("arst data", data, 0);
      check("arst busy", busy, 0);
      check("arst done", done_tick, 0);
      repeat (4) cyc();
      reset = 1'b1;
      exp_q.delete();
      words_q.delete();
      repeat (40) cyc();
      check("arst no_done", dones - d0, 0);
      check("arst idle", busy, 0);
      words_q.push_back(16'h0C35);
      start = 1'b1;
      cyc();
      start = 1'b0;
      wait_done("post_rst", 1'b0);

      // Randomized frames with varying tick rates
      for (int i = 0; i < 12; i++) begin
         m = $urandom_range(1, 6);
         w = 16'($urandom);
         words_q.push_back(w);
         repeat ($urandom_range(0, 5)) cyc();
         start = 1'b1;
         cyc();
         start = 1'b0;
         wait_done("rand", 1'b0);
      end
      check("dones match", dones10, dones);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
